// File: rtl/oled_screen_ctrl_pkg.sv
// Shared screen codes, button/switch indices and settings type for the OLED front-end controller.
// Screen codes match the top-level OLED data mux; the FSM state encoding reuses them directly.
package oled_screen_ctrl_pkg;

    typedef enum logic [2:0] {
        SCR_LOAD     = 3'd0,
        SCR_WELCOME  = 3'd1,
        SCR_MENU     = 3'd2,
        SCR_SOUNDBAR = 3'd3,
        SCR_DFT      = 3'd4,
        SCR_MAZE     = 3'd5,
        SCR_GEODASH  = 3'd6,
        SCR_BLANK    = 3'd7
    } screen_e;

    localparam int NUM_BTNS = 5;
    localparam int BTN_U    = 0;
    localparam int BTN_D    = 1;
    localparam int BTN_L    = 2;
    localparam int BTN_R    = 3;
    localparam int BTN_C    = 4;

    localparam int SW_EN       = 4;
    localparam int SW_SOUNDBAR = 3;
    localparam int SW_DFT      = 2;
    localparam int SW_MAZE     = 1;
    localparam int SW_GEODASH  = 0;

    typedef struct packed {
        logic [1:0] framesel;
        logic [1:0] soundbarpos;
        logic [1:0] coloursel;
    } settings_t;

    // Screen requested by the mode switches once the app layer is enabled.
    function automatic screen_e app_screen(logic [4:0] sw);
        if (sw[SW_SOUNDBAR])     return SCR_SOUNDBAR;
        else if (sw[SW_DFT])     return SCR_DFT;
        else if (sw[SW_MAZE])    return SCR_MAZE;
        else if (sw[SW_GEODASH]) return SCR_GEODASH;
        else                     return SCR_MENU;
    endfunction

endpackage

// File: rtl/oled_screen_ctrl_if.sv
// Button/switch inputs and screen/settings/app-pulse outputs of the OLED screen controller.
interface oled_screen_ctrl_if;
    logic       btnC, btnU, btnL, btnR, btnD;
    logic [4:0] sw;
    logic       load_done;
    logic [2:0] screen_sel;
    logic [1:0] framesel, soundbarpos, coloursel;
    logic       app_u, app_d, app_l, app_r, app_rst;

    modport slave (
        input  btnC, btnU, btnL, btnR, btnD, sw, load_done,
        output screen_sel, framesel, soundbarpos, coloursel,
        output app_u, app_d, app_l, app_r, app_rst
    );

    modport master (
        output btnC, btnU, btnL, btnR, btnD, sw, load_done,
        input  screen_sel, framesel, soundbarpos, coloursel,
        input  app_u, app_d, app_l, app_r, app_rst
    );
endinterface

// File: rtl/oled_screen_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-level counter and rising-edge press pulse.
module btn_debounce #(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic          prev_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) level_d = sync_q[1];
            else                             cnt_d   = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_q;
            press_q <= level_q & ~prev_q;
        end
    end

    assign press_o = press_q;
endmodule

// File: rtl/oled_screen_ctrl.sv
// OLED front-end sequencer: screen FSM, debounced button pulses, soundbar settings and app pulses.
// Optional SCREEN_BLANK_EN holds screen_sel at SCR_BLANK for BLANK_CYCLES after every state change.
module oled_screen_ctrl
    import oled_screen_ctrl_pkg::*;
#(
    parameter int DB_CYCLES    = 2_000_000,
    parameter int BLANK_CYCLES = 6_250_000
) (
    input  logic               CLOCK,
    input  logic               reset,
    oled_screen_ctrl_if.slave  bus
);
    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLOCK or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] press;

    assign btn_raw[BTN_U] = bus.btnU;
    assign btn_raw[BTN_D] = bus.btnD;
    assign btn_raw[BTN_L] = bus.btnL;
    assign btn_raw[BTN_R] = bus.btnR;
    assign btn_raw[BTN_C] = bus.btnC;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
        btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk     (CLOCK),
            .rst_n   (rst_n),
            .btn_i   (btn_raw[i]),
            .press_o (press[i])
        );
    end

    screen_e             state_q, state_d;
    settings_t           set_q, set_d;
    logic [NUM_BTNS-1:0] app_q, app_d;
    logic                blanking;

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        app_d   = '0;

        if (!bus.load_done)          state_d = SCR_LOAD;
        else if (state_q == SCR_LOAD) state_d = SCR_WELCOME;
        else if (!bus.sw[SW_EN])      state_d = SCR_WELCOME;
        else                          state_d = app_screen(bus.sw);

        // Presses act on the screen that was active when they arrived.
        if (state_q == SCR_SOUNDBAR && !blanking) begin
            if (press[BTN_U]) set_d.framesel    = set_q.framesel    + 2'd1;
            if (press[BTN_L]) set_d.soundbarpos = set_q.soundbarpos + 2'd1;
            if (press[BTN_R]) set_d.coloursel   = set_q.coloursel   + 2'd1;
        end

        if ((state_q == SCR_MAZE || state_q == SCR_GEODASH) && !blanking) app_d = press;
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCR_LOAD;
            set_q   <= '0;
            app_q   <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            app_q   <= app_d;
        end
    end

`ifdef SCREEN_BLANK_EN
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    screen_e       scr_q, scr_d;
    logic [BW-1:0] blank_cnt_q, blank_cnt_d;

    // A change while already blank reloads the count; the shown code is taken once the count expires.
    always_comb begin
        scr_d       = scr_q;
        blank_cnt_d = blank_cnt_q;
        if (state_d != state_q) begin
            scr_d       = SCR_BLANK;
            blank_cnt_d = BW'(BLANK_CYCLES - 1);
        end else if (blank_cnt_q != '0) begin
            blank_cnt_d = blank_cnt_q - 1'b1;
        end else begin
            scr_d = state_q;
        end
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            scr_q       <= SCR_LOAD;
            blank_cnt_q <= '0;
        end else begin
            scr_q       <= scr_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign blanking       = (scr_q == SCR_BLANK);
    assign bus.screen_sel = scr_q;
`else
    localparam int unused_blank_cycles = BLANK_CYCLES;

    assign blanking       = 1'b0;
    assign bus.screen_sel = state_q;
`endif

    assign bus.framesel    = set_q.framesel;
    assign bus.soundbarpos = set_q.soundbarpos;
    assign bus.coloursel   = set_q.coloursel;
    assign bus.app_u       = app_q[BTN_U];
    assign bus.app_d       = app_q[BTN_D];
    assign bus.app_l       = app_q[BTN_L];
    assign bus.app_r       = app_q[BTN_R];
    assign bus.app_rst     = app_q[BTN_C];
endmodule

// File: tb/tb_oled_screen_ctrl.sv
// Randomised self-checking bench for oled_screen_ctrl against a screen/settings/pulse reference model.
module tb_oled_screen_ctrl;
    localparam int DB    = 4;
    localparam int BLANK = 8;
`ifdef SCREEN_BLANK_EN
    localparam int SETTLE = BLANK + 3;
`else
    localparam int SETTLE = 1;
`endif

    logic CLOCK = 1'b0;
    logic reset = 1'b0;

    oled_screen_ctrl_if bus ();

    oled_screen_ctrl #(.DB_CYCLES(DB), .BLANK_CYCLES(BLANK)) dut (
        .CLOCK (CLOCK),
        .reset (reset),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int tests_run    = 0;
    int tests_failed = 0;

    // Running totals of app pulses; tests compare deltas.
    int tot_u = 0, tot_d = 0, tot_l = 0, tot_r = 0, tot_c = 0;
    always @(negedge CLOCK) begin
        if (bus.app_u)   tot_u++;
        if (bus.app_d)   tot_d++;
        if (bus.app_l)   tot_l++;
        if (bus.app_r)   tot_r++;
        if (bus.app_rst) tot_c++;
    end

    // Reference model state.
    int m_scr   = 0;
    int m_frame = 0, m_pos = 0, m_col = 0;

    int s_u, s_d, s_l, s_r, s_c;

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    function automatic int model_next(input int cur, input logic [4:0] sw, input logic ld);
        if (!ld)      return 0;
        if (cur == 0) return 1;
        if (!sw[4])   return 1;
        if (sw[3])    return 3;
        if (sw[2])    return 4;
        if (sw[1])    return 5;
        if (sw[0])    return 6;
        return 2;
    endfunction

    task automatic set_inputs(input logic [4:0] sw, input logic ld);
        bus.sw        = sw;
        bus.load_done = ld;
        for (int i = 0; i < SETTLE; i++) m_scr = model_next(m_scr, sw, ld);
        tick(SETTLE);
    endtask

    // mask bits: 0=U 1=D 2=L 3=R 4=C
    task automatic press(input logic [4:0] mask, input int hold);
        {bus.btnC, bus.btnR, bus.btnL, bus.btnD, bus.btnU} = mask;
        tick(hold);
        {bus.btnC, bus.btnR, bus.btnL, bus.btnD, bus.btnU} = 5'b0;
        tick(DB + 6);
    endtask

    task automatic snap();
        s_u = tot_u; s_d = tot_d; s_l = tot_l; s_r = tot_r; s_c = tot_c;
    endtask

    function automatic logic [5:0] m_settings();
        return {2'(m_frame), 2'(m_pos), 2'(m_col)};
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        bus.load_done = 1'b0;
        bus.sw = 5'b0;
        {bus.btnC, bus.btnR, bus.btnL, bus.btnD, bus.btnU} = 5'b0;
        tick(3);
        tests_run++;
        if (bus.screen_sel !== 3'd0) begin
            tests_failed++; $display("FAIL reset_screen got %0d want 0", bus.screen_sel);
        end
        tests_run++;
        if ({bus.framesel, bus.soundbarpos, bus.coloursel} !== 6'b0) begin
            tests_failed++; $display("FAIL reset_settings got %h want 0", {bus.framesel, bus.soundbarpos, bus.coloursel});
        end
        tests_run++;
        if ({bus.app_u, bus.app_d, bus.app_l, bus.app_r, bus.app_rst} !== 5'b0) begin
            tests_failed++; $display("FAIL reset_app got %b want 00000", {bus.app_u, bus.app_d, bus.app_l, bus.app_r, bus.app_rst});
        end
        reset = 1'b1;
        tick(4);
        m_scr = 0;
        tests_run++;
        if (bus.screen_sel !== 3'd0) begin
            tests_failed++; $display("FAIL load_hold got %0d want 0", bus.screen_sel);
        end
    endtask

    task automatic test_screen_sequence();
        logic [4:0] pats [4] = '{5'b00000, 5'b10000, 5'b11111, 5'b10111};
        int         exp  [4] = '{1, 2, 3, 4};
        for (int i = 0; i < 4; i++) begin
            set_inputs(pats[i], 1'b1);
            tests_run++;
            if (bus.screen_sel !== 3'(exp[i]) || m_scr != exp[i]) begin
                tests_failed++; $display("FAIL seq_%0d got %0d want %0d", i, bus.screen_sel, exp[i]);
            end
        end
    endtask

    task automatic test_soundbar_wrap();
        set_inputs(5'b11000, 1'b1);
        snap();
        for (int i = 0; i < 4; i++) begin
            press(5'b00001, 10);
            m_frame = (m_frame + 1) % 4;
            tests_run++;
            if (bus.framesel !== 2'(m_frame)) begin
                tests_failed++; $display("FAIL wrap_%0d framesel got %0d want %0d", i, bus.framesel, m_frame);
            end
        end
        press(5'b00100, 2);
        tests_run++;
        if (bus.soundbarpos !== 2'(m_pos)) begin
            tests_failed++; $display("FAIL glitch_l soundbarpos got %0d want %0d", bus.soundbarpos, m_pos);
        end
        tests_run++;
        if ((tot_u - s_u) + (tot_l - s_l) != 0) begin
            tests_failed++; $display("FAIL soundbar_app got %0d pulses want 0", (tot_u - s_u) + (tot_l - s_l));
        end
    endtask

    task automatic test_settings_random();
        logic [4:0] mask;
        int         hold;
        set_inputs(5'b11000, 1'b1);
        for (int i = 0; i < 24; i++) begin
            mask = 5'($urandom_range(1, 31));
            hold = $urandom_range(DB - 2, DB + 3);
            snap();
            press(mask, hold);
            if (hold >= DB) begin
                if (mask[0]) m_frame = (m_frame + 1) % 4;
                if (mask[2]) m_pos   = (m_pos + 1) % 4;
                if (mask[3]) m_col   = (m_col + 1) % 4;
            end
            tests_run++;
            if ({bus.framesel, bus.soundbarpos, bus.coloursel} !== m_settings()) begin
                tests_failed++;
                $display("FAIL rand_set_%0d mask=%b hold=%0d got %h want %h", i, mask, hold,
                         {bus.framesel, bus.soundbarpos, bus.coloursel}, m_settings());
            end
            tests_run++;
            if ((tot_u - s_u) + (tot_d - s_d) + (tot_l - s_l) + (tot_r - s_r) + (tot_c - s_c) != 0) begin
                tests_failed++; $display("FAIL rand_set_app_%0d got pulses want none", i);
            end
        end
    endtask

    task automatic test_app_pulses();
        logic [4:0] mask;
        logic [4:0] got;
        logic [4:0] want;
        int         hold;
        set_inputs(5'b10010, 1'b1);
        tests_run++;
        if (bus.screen_sel !== 3'd5) begin
            tests_failed++; $display("FAIL maze_screen got %0d want 5", bus.screen_sel);
        end
        snap();
        press(5'b01000, 10);
        tests_run++;
        if (tot_r - s_r != 1 || (tot_u - s_u) + (tot_d - s_d) + (tot_l - s_l) + (tot_c - s_c) != 0) begin
            tests_failed++; $display("FAIL maze_app_r got r=%0d want 1 others 0", tot_r - s_r);
        end
        tests_run++;
        if (bus.coloursel !== 2'(m_col)) begin
            tests_failed++; $display("FAIL maze_coloursel got %0d want %0d", bus.coloursel, m_col);
        end
        for (int i = 0; i < 12; i++) begin
            set_inputs($urandom_range(0, 1) ? 5'b10010 : 5'b10001, 1'b1);
            mask = 5'($urandom_range(1, 31));
            hold = $urandom_range(DB - 2, DB + 3);
            snap();
            press(mask, hold);
            want = (hold >= DB) ? mask : 5'b0;
            got  = {1'(tot_c - s_c), 1'(tot_r - s_r), 1'(tot_l - s_l), 1'(tot_d - s_d), 1'(tot_u - s_u)};
            tests_run++;
            if (got !== want || (tot_u - s_u) > 1 || (tot_r - s_r) > 1 || (tot_c - s_c) > 1) begin
                tests_failed++; $display("FAIL rand_app_%0d hold=%0d got %b want %b", i, hold, got, want);
            end
        end
        tests_run++;
        if ({bus.framesel, bus.soundbarpos, bus.coloursel} !== m_settings()) begin
            tests_failed++; $display("FAIL app_settings_hold got %h want %h", {bus.framesel, bus.soundbarpos, bus.coloursel}, m_settings());
        end
    endtask

    task automatic test_menu_gate();
        set_inputs(5'b10000, 1'b1);
        snap();
        press(5'b01000, 10);
        tests_run++;
        if (tot_r - s_r != 0) begin
            tests_failed++; $display("FAIL menu_app_r got %0d want 0", tot_r - s_r);
        end
        tests_run++;
        if (bus.coloursel !== 2'(m_col)) begin
            tests_failed++; $display("FAIL menu_coloursel got %0d want %0d", bus.coloursel, m_col);
        end
    endtask

    task automatic test_load_drop();
        set_inputs(5'b11000, 1'b1);
        press(5'b01101, 8);
        m_frame = (m_frame + 1) % 4; m_pos = (m_pos + 1) % 4; m_col = (m_col + 1) % 4;
        set_inputs(5'b11000, 1'b0);
        tests_run++;
        if (bus.screen_sel !== 3'd0) begin
            tests_failed++; $display("FAIL load_drop got %0d want 0", bus.screen_sel);
        end
        tests_run++;
        if ({bus.framesel, bus.soundbarpos, bus.coloursel} !== m_settings()) begin
            tests_failed++; $display("FAIL load_drop_settings got %h want %h", {bus.framesel, bus.soundbarpos, bus.coloursel}, m_settings());
        end
        set_inputs(5'b11000, 1'b1);
        tests_run++;
        if (bus.screen_sel !== 3'(m_scr)) begin
            tests_failed++; $display("FAIL load_return got %0d want %0d", bus.screen_sel, m_scr);
        end
    endtask

    task automatic test_random_screens();
        logic [4:0] sw;
        logic       ld;
        for (int i = 0; i < 30; i++) begin
            sw = 5'($urandom_range(0, 31));
            ld = ($urandom_range(0, 7) != 0);
            set_inputs(sw, ld);
            tests_run++;
            if (bus.screen_sel !== 3'(m_scr)) begin
                tests_failed++; $display("FAIL rand_scr_%0d sw=%b ld=%b got %0d want %0d", i, sw, ld, bus.screen_sel, m_scr);
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        set_inputs(5'b10010, 1'b1);
        snap();
        bus.btnU = 1'b1;
        tick(3);
        reset    = 1'b0;
        bus.btnU = 1'b0;
        tick(1);
        m_frame = 0; m_pos = 0; m_col = 0; m_scr = 0;
        tests_run++;
        if ({bus.framesel, bus.soundbarpos, bus.coloursel} !== 6'b0 || bus.screen_sel !== 3'd0) begin
            tests_failed++; $display("FAIL mid_reset_state got set=%h scr=%0d want 0", {bus.framesel, bus.soundbarpos, bus.coloursel}, bus.screen_sel);
        end
        tick(2);
        reset = 1'b1;
        tick(2 * SETTLE + DB + 10);
        m_scr = 5;
        tests_run++;
        if (tot_u - s_u != 0) begin
            tests_failed++; $display("FAIL mid_reset_pulse got %0d want 0", tot_u - s_u);
        end
        tests_run++;
        if (bus.screen_sel !== 3'd5) begin
            tests_failed++; $display("FAIL mid_reset_recover got %0d want 5", bus.screen_sel);
        end
    endtask

`ifdef SCREEN_BLANK_EN
    task automatic test_blank();
        set_inputs(5'b10000, 1'b1);
        bus.sw = 5'b10100;
        tick(1);
        for (int i = 0; i < BLANK; i++) begin
            tests_run++;
            if (bus.screen_sel !== 3'd7) begin
                tests_failed++; $display("FAIL blank_%0d got %0d want 7", i, bus.screen_sel);
            end
            tick(1);
        end
        tests_run++;
        if (bus.screen_sel !== 3'd4) begin
            tests_failed++; $display("FAIL blank_end got %0d want 4", bus.screen_sel);
        end
        m_scr = 4;
        set_inputs(5'b10000, 1'b1);
        snap();
        bus.btnR = 1'b1;
        tick(2);
        bus.sw = 5'b10010;
        tick(8);
        bus.btnR = 1'b0;
        tick(BLANK + DB + 6);
        m_scr = 5;
        tests_run++;
        if (tot_r - s_r != 0) begin
            tests_failed++; $display("FAIL blank_press got %0d want 0", tot_r - s_r);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_screen_sequence();
        test_soundbar_wrap();
        test_settings_random();
        test_app_pulses();
        test_menu_gate();
        test_load_drop();
        test_random_screens();
        test_reset_mid_debounce();
`ifdef SCREEN_BLANK_EN
        test_blank();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
